hls_out_framer: RTL and testbench

- Sits between the HLS wrapper's 32-bit ap_fifo output stream and the 32x512 FPGA-to-CPU FIFO on bus_clk.
- Collects result words into a frame buffer.
- Emits each frame as header, payload and trailer, so host software on the 32-bit read device can resynchronise and check integrity.
- Frames close on a programmable length or on an explicit flush.

---
 rtl/hls_out_framer.sv | 98 +++++++++
 tb/tb_hls_out_framer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hls_out_framer.sv
// hls_out_framer: packs HLS ap_fifo result words into header/payload/checksum frames for the host FIFO
module hls_out_framer #(
    parameter int          ADDR_W  = 8,
    parameter logic [15:0] HDR_TAG = 16'hA55A
) (
    input  logic            bus_clk,
    input  logic            srst,
    input  logic [ADDR_W:0] frame_len,
    input  logic            flush,
    input  logic [31:0]     in_din,
    input  logic            in_write,
    output logic            in_full_n,
    output logic [31:0]     out_din,
    output logic            out_wr_en,
    input  logic            out_full,
    output logic [15:0]     frame_count,
    output logic            busy
);
    typedef enum logic [1:0] {COLLECT, HEADER, PAYLOAD, TRAILER} state_t;
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};

    state_t          r_state, w_state_nxt;
    logic [31:0]     r_mem [0:(1<<ADDR_W)-1];
    logic [ADDR_W:0] r_count, r_len, r_ridx, w_len, w_cnt_nxt;
    logic [31:0]     r_sum, r_out, w_rd;
    logic [15:0]     r_frame_count;
    logic            r_pend, w_acc, w_close, w_wr, w_last, w_done;

    // The frame length is taken live while the buffer is empty and frozen once the first word lands.
    assign w_len       = (r_count == '0) ? ((frame_len == '0 || frame_len > DEPTH) ? DEPTH : frame_len) : r_len;
    assign in_full_n   = !srst && r_state == COLLECT && r_count < w_len;
    assign w_acc       = in_write && in_full_n;
    assign w_cnt_nxt   = r_count + {{ADDR_W{1'b0}}, w_acc};
    assign w_close     = r_state == COLLECT && ((w_acc && w_cnt_nxt == w_len) || (flush && w_cnt_nxt != '0));
    assign w_wr        = r_pend && !out_full && !srst;
    assign w_last      = r_ridx == r_count;
    assign w_done      = r_state == TRAILER && w_wr;
    assign w_rd        = r_mem[r_ridx[ADDR_W-1:0]];
    assign out_wr_en   = w_wr;
    assign out_din     = srst ? '0 : r_out;
    assign busy        = !srst && r_state != COLLECT;
    assign frame_count = srst ? '0 : r_frame_count;

    // Next-state: collect until full or flushed, then walk header, payload, trailer one consumed word at a time.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            COLLECT: if (w_close) w_state_nxt = HEADER;
            HEADER:  if (w_wr) w_state_nxt = PAYLOAD;
            PAYLOAD: if (w_wr && w_last) w_state_nxt = TRAILER;
            default: if (w_wr) w_state_nxt = COLLECT;
        endcase
    end

    // Payload buffer write port; contents need no reset.
    always_ff @(posedge bus_clk) begin
        if (w_acc) r_mem[r_count[ADDR_W-1:0]] <= in_din;
    end

    // Control and output register: the next word is fetched into r_out as the current one is consumed, so no bubbles.
    always_ff @(posedge bus_clk) begin
        if (srst) begin
            r_state       <= COLLECT;
            r_count       <= '0;
            r_len         <= DEPTH;
            r_sum         <= '0;
            r_frame_count <= '0;
            r_out         <= '0;
            r_pend        <= 1'b0;
            r_ridx        <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_frame_count <= r_frame_count + {15'd0, w_done};
            if (r_state == COLLECT) begin
                if (r_count == '0) r_len <= w_len;
                r_count <= w_cnt_nxt;
                if (w_acc) r_sum <= r_sum + in_din;
                if (w_close) begin
                    r_out  <= {HDR_TAG, 16'(w_cnt_nxt)};
                    r_pend <= 1'b1;
                    r_ridx <= '0;
                end
            end else if (w_wr) begin
                r_ridx <= r_ridx + ONE;
                r_out  <= (r_state == PAYLOAD && w_last) ? r_sum : w_rd;
                if (r_state == TRAILER) begin
                    r_pend  <= 1'b0;
                    r_count <= '0;
                    r_sum   <= '0;
                end
            end
        end
    end

    // The HLS core must never push while it is being held off.
    a_no_overrun: assert property (@(posedge bus_clk) disable iff (srst) in_write |-> in_full_n);
endmodule

// File: tb/tb_hls_out_framer.sv
// tb_hls_out_framer: scoreboard bench for hls_out_framer
module tb_hls_out_framer;
    logic        bus_clk = 1'b0, srst = 1'b1, flush = 1'b0, in_write = 1'b0, out_full = 1'b0;
    logic [8:0]  frame_len = 9'd4;
    logic [31:0] in_din = 32'd0;
    logic        in_full_n, out_wr_en, busy;
    logic [31:0] out_din;
    logic [15:0] frame_count;
    logic [31:0] exp_q[$], got_q[$], pay[$];
    int          got_c[$];
    int          cyc = 0, n_chk = 0, n_fail = 0;
    logic [15:0] exp_fc = 16'd0;

    hls_out_framer dut (
        .bus_clk(bus_clk), .srst(srst), .frame_len(frame_len), .flush(flush),
        .in_din(in_din), .in_write(in_write), .in_full_n(in_full_n),
        .out_din(out_din), .out_wr_en(out_wr_en), .out_full(out_full),
        .frame_count(frame_count), .busy(busy)
    );

    always #5 bus_clk = ~bus_clk;
    always @(posedge bus_clk) cyc <= cyc + 1;
    // Capture every word the DUT writes downstream.
    always @(negedge bus_clk) if (out_wr_en) begin
        got_q.push_back(out_din);
        got_c.push_back(cyc);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge bus_clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] d, input logic fl);
        int k = 0;
        while (!in_full_n && k < 1000) begin
            tick();
            k++;
        end
        n_chk++;
        if (!in_full_n) begin
            n_fail++;
            $display("FAIL send_wait in_full_n=%b required 1", in_full_n);
        end else begin
            in_din = d; in_write = 1'b1; flush = fl;
            tick();
            in_write = 1'b0; flush = 1'b0;
        end
    endtask

    task automatic send_frame(input logic fl_last);
        logic [31:0] s = 32'd0;
        exp_q.push_back({16'hA55A, 16'(pay.size())});
        foreach (pay[i]) begin
            exp_q.push_back(pay[i]);
            s += pay[i];
        end
        exp_q.push_back(s);
        foreach (pay[i]) send_word(pay[i], fl_last && i == pay.size() - 1);
        pay.delete();
    endtask

    task automatic wait_out(input int n);
        for (int k = 0; k < 2000 && got_q.size() < n; k++) tick();
    endtask

    task automatic wait_open(output int c);
        c = 0;
        while (!in_full_n && c < 2000) begin
            c++;
            tick();
        end
    endtask

    task automatic test_reset;
        srst = 1'b1; frame_len = 9'd4;
        tick(); tick();
        n_chk++; if (in_full_n !== 1'b0) begin n_fail++; $display("FAIL rst_in_full_n got=%b exp=0", in_full_n); end
        n_chk++; if (out_wr_en !== 1'b0) begin n_fail++; $display("FAIL rst_wr_en got=%b exp=0", out_wr_en); end
        n_chk++; if (out_din !== 32'd0) begin n_fail++; $display("FAIL rst_out_din got=%h exp=0", out_din); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b exp=0", busy); end
        n_chk++; if (frame_count !== 16'd0) begin n_fail++; $display("FAIL rst_frame_count got=%0d exp=0", frame_count); end
        srst = 1'b0;
        #1;
        n_chk++; if (in_full_n !== 1'b1) begin n_fail++; $display("FAIL post_rst_in_full_n got=%b exp=1", in_full_n); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL post_rst_busy got=%b exp=0", busy); end
        tick();
    endtask

    task automatic test_basic;
        int c;
        logic [31:0] e, g;
        frame_len = 9'd4;
        for (int i = 1; i <= 4; i++) pay.push_back(32'(i));
        send_frame(1'b0);
        wait_open(c);
        n_chk++; if (c != 6) begin n_fail++; $display("FAIL basic_hold got=%0d cycles exp=6", c); end
        exp_fc++;
        n_chk++; if (frame_count !== exp_fc) begin n_fail++; $display("FAIL basic_frame_count got=%0d exp=%0d", frame_count, exp_fc); end
        n_chk++;
        if (got_c.size() != 6 || got_c[5] - got_c[0] != 5) begin
            n_fail++; $display("FAIL basic_consecutive got=%0d writes exp=6 back-to-back", got_c.size());
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (got_q.size() > 0) g = got_q.pop_front(); else g = 32'hxxxxxxxx;
            n_chk++; if (g !== e) begin n_fail++; $display("FAIL basic_word got=%h exp=%h", g, e); end
        end
        n_chk++; if (got_q.size() != 0) begin n_fail++; $display("FAIL basic_extra got=%0d words exp=0", got_q.size()); end
        got_q.delete(); got_c.delete();
    endtask

    task automatic test_full_depth;
        int c;
        logic [31:0] e, g;
        frame_len = 9'd0;
        repeat (256) pay.push_back(32'hFFFFFFFF);
        send_frame(1'b0);
        n_chk++; if (in_full_n !== 1'b0) begin n_fail++; $display("FAIL depth_full_n got=%b exp=0", in_full_n); end
        wait_open(c);
        n_chk++; if (c != 258) begin n_fail++; $display("FAIL depth_hold got=%0d cycles exp=258", c); end
        pay.push_back(32'h12345678);
        send_frame(1'b1);
        wait_out(261);
        wait_open(c);
        exp_fc += 16'd2;
        n_chk++; if (frame_count !== exp_fc) begin n_fail++; $display("FAIL depth_frame_count got=%0d exp=%0d", frame_count, exp_fc); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (got_q.size() > 0) g = got_q.pop_front(); else g = 32'hxxxxxxxx;
            n_chk++; if (g !== e) begin n_fail++; $display("FAIL depth_word got=%h exp=%h", g, e); end
        end
        got_q.delete(); got_c.delete();
    endtask

    task automatic test_flush;
        int c;
        logic [31:0] e, g;
        frame_len = 9'd8;
        pay.push_back(32'h10); pay.push_back(32'h20); pay.push_back(32'h30);
        send_frame(1'b1);
        wait_out(5);
        wait_open(c);
        exp_fc++;
        n_chk++; if (frame_count !== exp_fc) begin n_fail++; $display("FAIL flush_frame_count got=%0d exp=%0d", frame_count, exp_fc); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (got_q.size() > 0) g = got_q.pop_front(); else g = 32'hxxxxxxxx;
            n_chk++; if (g !== e) begin n_fail++; $display("FAIL flush_word got=%h exp=%h", g, e); end
        end
        flush = 1'b1;
        repeat (5) tick();
        flush = 1'b0;
        repeat (5) tick();
        n_chk++; if (got_q.size() != 0) begin n_fail++; $display("FAIL empty_flush_writes got=%0d exp=0", got_q.size()); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL empty_flush_busy got=%b exp=0", busy); end
        n_chk++; if (frame_count !== exp_fc) begin n_fail++; $display("FAIL empty_flush_count got=%0d exp=%0d", frame_count, exp_fc); end
        got_q.delete(); got_c.delete();
    endtask

    task automatic test_backpressure;
        logic [31:0] e, g, pd;
        logic pf = 1'b0, pb = 1'b0;
        frame_len = 9'd4;
        out_full = 1'b1;
        for (int i = 1; i <= 4; i++) pay.push_back(32'(i));
        send_frame(1'b0);
        for (int k = 0; k < 400 && !(got_q.size() == 6 && !busy); k++) begin
            @(negedge bus_clk);
            if (pf && pb) begin
                n_chk++; if (out_din !== pd) begin n_fail++; $display("FAIL bp_stable got=%h exp=%h", out_din, pd); end
            end
            pf = out_full; pb = busy; pd = out_din;
            tick();
            out_full = 1'($urandom_range(0, 1));
        end
        out_full = 1'b0;
        repeat (5) tick();
        n_chk++; if (got_q.size() != 6) begin n_fail++; $display("FAIL bp_writes got=%0d exp=6", got_q.size()); end
        exp_fc++;
        n_chk++; if (frame_count !== exp_fc) begin n_fail++; $display("FAIL bp_frame_count got=%0d exp=%0d", frame_count, exp_fc); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (got_q.size() > 0) g = got_q.pop_front(); else g = 32'hxxxxxxxx;
            n_chk++; if (g !== e) begin n_fail++; $display("FAIL bp_word got=%h exp=%h", g, e); end
        end
        got_q.delete(); got_c.delete();
    endtask

    task automatic test_reset_mid;
        int c;
        logic [31:0] e, g;
        frame_len = 9'd4;
        exp_q.push_back(32'hA55A0004); exp_q.push_back(32'hB1); exp_q.push_back(32'hB2);
        for (int i = 1; i <= 4; i++) send_word(32'hB0 + 32'(i), 1'b0);
        tick(); tick(); tick();
        srst = 1'b1;
        #1;
        n_chk++; if (out_wr_en !== 1'b0) begin n_fail++; $display("FAIL mid_rst_wr_en got=%b exp=0", out_wr_en); end
        tick(); tick();
        srst = 1'b0;
        exp_fc = 16'd0;
        repeat (10) tick();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (got_q.size() > 0) g = got_q.pop_front(); else g = 32'hxxxxxxxx;
            n_chk++; if (g !== e) begin n_fail++; $display("FAIL mid_word got=%h exp=%h", g, e); end
        end
        n_chk++; if (got_q.size() != 0) begin n_fail++; $display("FAIL mid_extra got=%0d words exp=0", got_q.size()); end
        n_chk++; if (frame_count !== 16'd0) begin n_fail++; $display("FAIL mid_frame_count got=%0d exp=0", frame_count); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy got=%b exp=0", busy); end
        got_q.delete(); got_c.delete();
        frame_len = 9'd2;
        pay.push_back(32'hCAFE0001); pay.push_back(32'hCAFE0002);
        send_frame(1'b0);
        wait_out(4);
        wait_open(c);
        exp_fc++;
        n_chk++; if (frame_count !== exp_fc) begin n_fail++; $display("FAIL mid_next_count got=%0d exp=%0d", frame_count, exp_fc); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (got_q.size() > 0) g = got_q.pop_front(); else g = 32'hxxxxxxxx;
            n_chk++; if (g !== e) begin n_fail++; $display("FAIL mid_next_word got=%h exp=%h", g, e); end
        end
        got_q.delete(); got_c.delete();
    endtask

    task automatic test_wrap;
        int c;
        logic [31:0] e, g;
        frame_len = 9'd1;
        for (int f = 0; f < 5; f++) begin
            if (f == 2) begin
                force dut.r_frame_count = 16'hFFFE;
                tick();
                release dut.r_frame_count;
                exp_fc = 16'hFFFE;
            end
            pay.push_back($urandom);
            send_frame(1'b0);
            wait_out(3);
            wait_open(c);
            exp_fc++;
            n_chk++; if (frame_count !== exp_fc) begin n_fail++; $display("FAIL wrap_count got=%h exp=%h", frame_count, exp_fc); end
            n_chk++; if (got_q.size() != 3) begin n_fail++; $display("FAIL wrap_writes got=%0d exp=3", got_q.size()); end
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (got_q.size() > 0) g = got_q.pop_front(); else g = 32'hxxxxxxxx;
                n_chk++; if (g !== e) begin n_fail++; $display("FAIL wrap_word got=%h exp=%h", g, e); end
            end
            got_q.delete(); got_c.delete();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full_depth();
        test_flush();
        test_backpressure();
        test_reset_mid();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
